// File: rtl/uart_cmd_ctrl_if.sv
// Bundles the UART byte strobes, the word-FIFO ports and the status outputs of
// the UART command sequencer. The master side is the controller itself.
interface uart_cmd_ctrl_if;
    logic        rx_strobe;
    logic [7:0]  rx_data;
    logic        rx_err;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        fifo_wr_en;
    logic [15:0] fifo_din;
    logic        fifo_full;
    logic        fifo_rd_en;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        start_pulse;
    logic        err_flag;
    logic        drop_flag;
    logic        busy;

    modport master (
        input  rx_strobe, rx_data, rx_err, tx_busy, fifo_full, fifo_dout, fifo_empty,
        output tx_start, tx_data, fifo_wr_en, fifo_din, fifo_rd_en,
               start_pulse, err_flag, drop_flag, busy
    );

    modport slave (
        output rx_strobe, rx_data, rx_err, tx_busy, fifo_full, fifo_dout, fifo_empty,
        input  tx_start, tx_data, fifo_wr_en, fifo_din, fifo_rd_en,
               start_pulse, err_flag, drop_flag, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: parses command frames from the received byte stream,
// pushes assembled 16-bit words into the FIFO, pops words back out as byte
// pairs, answers status queries and strobes the downstream core.
// Every output is a register; combinational logic computes their next values.
module uart_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input logic             clk,
    input logic             rst,
    uart_cmd_ctrl_if.master bus
);
    localparam logic [7:0]      CMD_WRITE  = 8'h80;
    localparam logic [7:0]      CMD_READ   = 8'h10;
    localparam logic [7:0]      CMD_STATUS = 8'h40;
    localparam logic [7:0]      CMD_START  = 8'h20;
    localparam logic [7:0]      CMD_CLEAR  = 8'h08;
    localparam logic [7:0]      EMPTY_BYTE = 8'hEE;
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_HI, S_WR_LO, S_PUSH, S_POP, S_CAPT, S_TX_HI, S_TX_LO, S_TX_ST
    } state_t;

    // Sub-steps of every transmit state. tx_start is visible during IGN0;
    // tx_busy is not trusted during IGN0 and IGN1.
    typedef enum logic [1:0] {
        PH_WAIT0, PH_IGN0, PH_IGN1, PH_WAIT1
    } phase_t;

    state_t          state, state_nxt;
    phase_t          phase, phase_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic [7:0]      hi_byte, hi_byte_nxt;
    logic [15:0]     rd_word, rd_word_nxt;
    logic [7:0]      pend_byte;
    logic            tx_issue;
    logic [7:0]      tx_byte;
    logic            timeout;
    logic [7:0]      status_byte;

    logic            tx_start_nxt;
    logic [7:0]      tx_data_nxt;
    logic            fifo_wr_en_nxt;
    logic [15:0]     fifo_din_nxt;
    logic            fifo_rd_en_nxt;
    logic            start_pulse_nxt;
    logic            err_set, drop_set, flag_clr;
    logic            err_flag_nxt, drop_flag_nxt, busy_nxt;

    assign timeout     = (state == S_WR_HI || state == S_WR_LO) && (to_cnt == TO_LAST);
    assign status_byte = {bus.fifo_full, bus.fifo_empty, bus.err_flag, bus.drop_flag, 4'hA};

    // State register: FSM state, transmit sub-step and inter-byte timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            phase  <= PH_WAIT0;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            phase  <= phase_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end

    // Next-state logic, including when a byte is handed to the transmitter
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        to_cnt_nxt = '0;
        tx_issue   = 1'b0;
        tx_byte    = pend_byte;
        case (state)
            S_IDLE: begin
                if (bus.rx_strobe && !bus.rx_err) begin
                    case (bus.rx_data)
                        CMD_WRITE:  state_nxt = S_WR_HI;
                        CMD_READ:   state_nxt = S_POP;
                        CMD_STATUS: begin
                            state_nxt = S_TX_ST;
                            tx_issue  = !bus.tx_busy;
                            tx_byte   = status_byte;
                        end
                        default:    state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WR_HI, S_WR_LO: begin
                if (bus.rx_err || timeout) begin
                    state_nxt = S_IDLE;
                end else if (bus.rx_strobe) begin
                    state_nxt = (state == S_WR_HI) ? S_WR_LO : S_PUSH;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            S_PUSH: state_nxt = S_IDLE;
            S_POP: begin
                // No pop was issued when the FIFO was empty: answer with a marker byte.
                if (bus.fifo_rd_en) begin
                    state_nxt = S_CAPT;
                end else begin
                    state_nxt = S_TX_ST;
                    tx_issue  = !bus.tx_busy;
                    tx_byte   = EMPTY_BYTE;
                end
            end
            S_CAPT: begin
                state_nxt = S_TX_HI;
                tx_issue  = !bus.tx_busy;
                tx_byte   = bus.fifo_dout[15:8];
            end
            default: begin
                case (phase)
                    PH_WAIT0: tx_issue  = !bus.tx_busy;
                    PH_IGN0:  phase_nxt = PH_IGN1;
                    PH_IGN1:  phase_nxt = PH_WAIT1;
                    default: begin
                        if (!bus.tx_busy) begin
                            if (state == S_TX_HI) begin
                                state_nxt = S_TX_LO;
                                tx_issue  = 1'b1;
                                tx_byte   = rd_word[7:0];
                            end else begin
                                state_nxt = S_IDLE;
                            end
                        end
                    end
                endcase
            end
        endcase
        if (tx_issue) begin
            phase_nxt = PH_IGN0;
        end else if (state_nxt != state) begin
            phase_nxt = PH_WAIT0;
        end
    end

    // Output logic: next values of the registered pulses, data and sticky flags
    always_comb begin
        tx_start_nxt    = tx_issue;
        tx_data_nxt     = tx_issue ? tx_byte : bus.tx_data;
        fifo_wr_en_nxt  = 1'b0;
        fifo_din_nxt    = bus.fifo_din;
        fifo_rd_en_nxt  = 1'b0;
        start_pulse_nxt = 1'b0;
        err_set         = 1'b0;
        drop_set        = 1'b0;
        flag_clr        = 1'b0;
        hi_byte_nxt     = hi_byte;
        rd_word_nxt     = rd_word;
        case (state)
            S_IDLE: begin
                if (bus.rx_err) begin
                    err_set = 1'b1;
                end else if (bus.rx_strobe) begin
                    case (bus.rx_data)
                        CMD_WRITE, CMD_STATUS: err_set = 1'b0;
                        CMD_READ:   fifo_rd_en_nxt  = !bus.fifo_empty;
                        CMD_START:  start_pulse_nxt = 1'b1;
                        CMD_CLEAR:  flag_clr        = 1'b1;
                        default:    err_set         = 1'b1;
                    endcase
                end
            end
            S_WR_HI: begin
                if (bus.rx_err || timeout) begin
                    err_set = 1'b1;
                end else if (bus.rx_strobe) begin
                    hi_byte_nxt = bus.rx_data;
                end
            end
            S_WR_LO: begin
                if (bus.rx_err || timeout) begin
                    err_set = 1'b1;
                end else if (bus.rx_strobe) begin
                    if (!bus.fifo_full) begin
                        fifo_wr_en_nxt = 1'b1;
                        fifo_din_nxt   = {hi_byte, bus.rx_data};
                    end else begin
                        drop_set = 1'b1;
                    end
                end
            end
            S_CAPT: rd_word_nxt = bus.fifo_dout;
            default: rd_word_nxt = rd_word;
        endcase
        // Bytes arriving while the controller is busy with a reply or push are rejected.
        if (bus.rx_strobe && !(state inside {S_IDLE, S_WR_HI, S_WR_LO})) begin
            err_set = 1'b1;
        end
        // A new error outranks a simultaneous CLEAR.
        err_flag_nxt  = err_set  | (bus.err_flag  & !flag_clr);
        drop_flag_nxt = drop_set | (bus.drop_flag & !flag_clr);
        busy_nxt      = (state_nxt != S_IDLE);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.tx_start    <= 1'b0;
            bus.tx_data     <= 8'h00;
            bus.fifo_wr_en  <= 1'b0;
            bus.fifo_din    <= 16'h0000;
            bus.fifo_rd_en  <= 1'b0;
            bus.start_pulse <= 1'b0;
            bus.err_flag    <= 1'b0;
            bus.drop_flag   <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.tx_start    <= tx_start_nxt;
            bus.tx_data     <= tx_data_nxt;
            bus.fifo_wr_en  <= fifo_wr_en_nxt;
            bus.fifo_din    <= fifo_din_nxt;
            bus.fifo_rd_en  <= fifo_rd_en_nxt;
            bus.start_pulse <= start_pulse_nxt;
            bus.err_flag    <= err_flag_nxt;
            bus.drop_flag   <= drop_flag_nxt;
            bus.busy        <= busy_nxt;
        end
    end

    // Word assembly and reply staging; only meaningful while a frame is active
    always_ff @(posedge clk) begin
        hi_byte   <= hi_byte_nxt;
        rd_word   <= rd_word_nxt;
        pend_byte <= tx_byte;
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a small FIFO model and a UART
// transmitter model that stays busy for six cycles after each tx_start.
module tb_uart_cmd_ctrl;
    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_full = 1'b0;
    int   cmp  = 0;
    int   fail = 0;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // FIFO model
    logic [15:0] fmem [0:7];
    int wp = 0;
    int rp = 0;
    always @(posedge clk) begin
        if (bus.fifo_wr_en) begin
            fmem[wp % 8] <= bus.fifo_din;
            wp <= wp + 1;
        end
        if (bus.fifo_rd_en) begin
            bus.fifo_dout <= fmem[rp % 8];
            rp <= rp + 1;
        end
    end
    assign bus.fifo_empty = (wp == rp);
    assign bus.fifo_full  = force_full;

    // UART transmitter model
    int tx_cnt = 0;
    always @(posedge clk) begin
        if (bus.tx_start) tx_cnt <= 6;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign bus.tx_busy = (tx_cnt != 0);

    // Event monitor
    logic [7:0] tx_log [0:15];
    int tx_n = 0, tx_viol = 0, wr_cnt = 0, rd_cnt = 0, start_cnt = 0, both_cnt = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.tx_start) begin
                tx_log[tx_n % 16] <= bus.tx_data;
                tx_n <= tx_n + 1;
                if (bus.tx_busy) tx_viol <= tx_viol + 1;
            end
            if (bus.fifo_wr_en) wr_cnt <= wr_cnt + 1;
            if (bus.fifo_rd_en) rd_cnt <= rd_cnt + 1;
            if (bus.start_pulse) start_cnt <= start_cnt + 1;
            if (bus.fifo_wr_en && bus.fifo_rd_en) both_cnt <= both_cnt + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Strobe one byte; returns at the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_strobe = 1'b1;
        bus.rx_data   = b;
        @(negedge clk);
        bus.rx_strobe = 1'b0;
        bus.rx_data   = 8'h00;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [42:0] got;
        got = {bus.tx_start, bus.tx_data, bus.fifo_wr_en, bus.fifo_din, bus.fifo_rd_en,
               bus.start_pulse, bus.err_flag, bus.drop_flag, bus.busy, 8'h00};
        cmp++;
        if (got !== 43'd0) begin
            fail++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        cmp++;
        if (bus.busy !== 1'b0) begin
            fail++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_write();
        bit ok;
        send_byte(8'h80);
        cmp++;
        if (bus.busy !== 1'b1) begin fail++; $display("FAIL write_busy_hi: got %b want 1", bus.busy); end
        send_byte(8'h12);
        send_byte(8'h34);
        cmp++;
        if (bus.fifo_wr_en !== 1'b1) begin fail++; $display("FAIL write_wr_en: got %b want 1", bus.fifo_wr_en); end
        cmp++;
        if (bus.fifo_din !== 16'h1234) begin fail++; $display("FAIL write_din: got %h want 1234", bus.fifo_din); end
        @(negedge clk);
        cmp++;
        if (bus.fifo_wr_en !== 1'b0) begin fail++; $display("FAIL write_wr_en_width: got %b want 0", bus.fifo_wr_en); end
        wait_idle(10, ok);
        cmp++;
        if (!ok) begin fail++; $display("FAIL write_idle: busy got 1 want 0"); end
        cmp++;
        if (wr_cnt !== 1) begin fail++; $display("FAIL write_count: got %0d want 1", wr_cnt); end
    endtask

    task automatic test_read();
        bit ok;
        int base;
        base = tx_n;
        send_byte(8'h10);
        cmp++;
        if (bus.fifo_rd_en !== 1'b1) begin fail++; $display("FAIL read_rd_en: got %b want 1", bus.fifo_rd_en); end
        @(negedge clk);
        cmp++;
        if (bus.tx_start !== 1'b0) begin fail++; $display("FAIL read_early_start: got %b want 0", bus.tx_start); end
        @(negedge clk);
        cmp++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h12) begin
            fail++;
            $display("FAIL read_hi_start: got start=%b data=%h want start=1 data=12", bus.tx_start, bus.tx_data);
        end
        wait_idle(100, ok);
        cmp++;
        if (!ok) begin fail++; $display("FAIL read_idle: busy got 1 want 0"); end
        cmp++;
        if (tx_n - base !== 2) begin fail++; $display("FAIL read_tx_count: got %0d want 2", tx_n - base); end
        cmp++;
        if (tx_log[base % 16] !== 8'h12 || tx_log[(base + 1) % 16] !== 8'h34) begin
            fail++;
            $display("FAIL read_bytes: got %h %h want 12 34", tx_log[base % 16], tx_log[(base + 1) % 16]);
        end
        cmp++;
        if (rd_cnt !== 1) begin fail++; $display("FAIL read_rd_count: got %0d want 1", rd_cnt); end
    endtask

    task automatic test_read_empty_status();
        bit ok;
        int base;
        base = tx_n;
        send_byte(8'h10);
        cmp++;
        if (bus.fifo_rd_en !== 1'b0) begin fail++; $display("FAIL empty_rd_en: got %b want 0", bus.fifo_rd_en); end
        wait_idle(100, ok);
        cmp++;
        if (!ok) begin fail++; $display("FAIL empty_idle: busy got 1 want 0"); end
        cmp++;
        if (tx_n - base !== 1 || tx_log[base % 16] !== 8'hEE) begin
            fail++;
            $display("FAIL empty_byte: got count=%0d byte=%h want count=1 byte=ee", tx_n - base, tx_log[base % 16]);
        end
        cmp++;
        if (rd_cnt !== 1) begin fail++; $display("FAIL empty_rd_count: got %0d want 1", rd_cnt); end
        send_byte(8'h40);
        cmp++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h4A) begin
            fail++;
            $display("FAIL status_4a: got start=%b data=%h want start=1 data=4a", bus.tx_start, bus.tx_data);
        end
        wait_idle(100, ok);
        cmp++;
        if (!ok) begin fail++; $display("FAIL status_idle: busy got 1 want 0"); end
    endtask

    task automatic test_timeout();
        bit ok;
        send_byte(8'h80);
        send_byte(8'hAB);
        repeat (TO - 10) @(negedge clk);
        cmp++;
        if (bus.busy !== 1'b1) begin fail++; $display("FAIL timeout_early: busy got %b want 1", bus.busy); end
        repeat (15) @(negedge clk);
        cmp++;
        if (bus.busy !== 1'b0) begin fail++; $display("FAIL timeout_idle: busy got %b want 0", bus.busy); end
        cmp++;
        if (bus.err_flag !== 1'b1) begin fail++; $display("FAIL timeout_err: got %b want 1", bus.err_flag); end
        cmp++;
        if (wr_cnt !== 1) begin fail++; $display("FAIL timeout_no_push: got %0d want 1", wr_cnt); end
        send_byte(8'h40);
        cmp++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h6A) begin
            fail++;
            $display("FAIL status_6a: got start=%b data=%h want start=1 data=6a", bus.tx_start, bus.tx_data);
        end
        wait_idle(100, ok);
        cmp++;
        if (!ok) begin fail++; $display("FAIL status2_idle: busy got 1 want 0"); end
    endtask

    task automatic test_full_clear();
        force_full = 1'b1;
        send_byte(8'h80);
        send_byte(8'h11);
        send_byte(8'h22);
        cmp++;
        if (bus.fifo_wr_en !== 1'b0) begin fail++; $display("FAIL full_wr_en: got %b want 0", bus.fifo_wr_en); end
        cmp++;
        if (bus.drop_flag !== 1'b1) begin fail++; $display("FAIL full_drop: got %b want 1", bus.drop_flag); end
        @(negedge clk);
        force_full = 1'b0;
        cmp++;
        if (wr_cnt !== 1) begin fail++; $display("FAIL full_count: got %0d want 1", wr_cnt); end
        send_byte(8'h08);
        cmp++;
        if (bus.err_flag !== 1'b0 || bus.drop_flag !== 1'b0) begin
            fail++;
            $display("FAIL clear_flags: got err=%b drop=%b want 0 0", bus.err_flag, bus.drop_flag);
        end
    endtask

    task automatic test_unknown_start();
        send_byte(8'h55);
        cmp++;
        if (bus.err_flag !== 1'b1) begin fail++; $display("FAIL unknown_err: got %b want 1", bus.err_flag); end
        cmp++;
        if (bus.busy !== 1'b0) begin fail++; $display("FAIL unknown_busy: got %b want 0", bus.busy); end
        send_byte(8'h20);
        cmp++;
        if (bus.start_pulse !== 1'b1) begin fail++; $display("FAIL start_pulse: got %b want 1", bus.start_pulse); end
        @(negedge clk);
        cmp++;
        if (bus.start_pulse !== 1'b0 || start_cnt !== 1) begin
            fail++;
            $display("FAIL start_width: got pulse=%b count=%0d want 0 1", bus.start_pulse, start_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        logic [42:0] got;
        send_byte(8'h80);
        send_byte(8'h56);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got = {bus.tx_start, bus.tx_data, bus.fifo_wr_en, bus.fifo_din, bus.fifo_rd_en,
               bus.start_pulse, bus.err_flag, bus.drop_flag, bus.busy, 8'h00};
        cmp++;
        if (got !== 43'd0) begin fail++; $display("FAIL midreset_outputs: got %h want 0", got); end
        repeat (3) @(negedge clk);
        cmp++;
        if (wr_cnt !== 1 || bus.busy !== 1'b0) begin
            fail++;
            $display("FAIL midreset_no_push: got count=%0d busy=%b want 1 0", wr_cnt, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        cmp++;
        if (both_cnt !== 0) begin fail++; $display("FAIL wr_rd_overlap: got %0d want 0", both_cnt); end
        cmp++;
        if (tx_viol !== 0) begin fail++; $display("FAIL tx_start_while_busy: got %0d want 0", tx_viol); end
    endtask

    initial begin
        bus.rx_strobe = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_err    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_read_empty_status();
        test_timeout();
        test_full_clear();
        test_unknown_start();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
        $finish;
    end
endmodule
